// File: rtl/common.sv
// Shared scalar types used across the pipeline.
package common;
  typedef logic        u1;
  typedef logic [63:0] u64;
endpackage

// File: rtl/pipes.sv
// Pipeline-wide enums for the execute-stage divider.
package pipes;
  typedef enum logic [1:0] {
    DIV  = 2'd0,
    DIVU = 2'd1,
    REM  = 2'd2,
    REMU = 2'd3
  } div_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;
endpackage

// File: rtl/exe_divider.sv
// Iterative 64-bit restoring divider for the EX stage.
// Stalls ID/EX via exe_is_waiting until the result is ready.
module exe_divider
  import common::*;
  import pipes::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    valid,
  input  div_op_t op,
  input  u64      srca,
  input  u64      srcb,
  input  logic    flush,
  input  logic    hold,
  output logic    exe_is_waiting,
  output logic    done,
  output u64      result
);

  div_state_t state, state_nx;

  div_op_t    op_q;
  u64         quo_q;
  u64         rem_q;
  u64         dvs_q;
  logic       negq_q;
  logic       negr_q;
  logic [6:0] cnt_q;

  logic       signed_op;
  logic       a_neg;
  logic       b_neg;
  u64         a_mag;
  u64         b_mag;
  logic       div0;
  logic       ovf;
  logic       start;

  assign signed_op = (op == DIV) || (op == REM);
  assign a_neg     = signed_op & srca[63];
  assign b_neg     = signed_op & srcb[63];
  assign a_mag     = a_neg ? (~srca + 64'd1) : srca;
  assign b_mag     = b_neg ? (~srcb + 64'd1) : srcb;
  assign div0      = (srcb == 64'd0);
  assign ovf       = signed_op
                   && (srca == 64'h8000_0000_0000_0000)
                   && (srcb == 64'hFFFF_FFFF_FFFF_FFFF);
  assign start     = (state == IDLE) && valid && !flush;

  // One restoring step: shift next dividend bit in, try subtract.
  logic [64:0] shifted;
  logic [65:0] trial;
  assign shifted = {rem_q, quo_q[63]};
  assign trial   = {1'b0, shifted} - {2'b00, dvs_q};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start) state_nx = (div0 || ovf) ? DONE : BUSY;
      BUSY: if (cnt_q == 7'd63) state_nx = DONE;
      DONE: if (!hold) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (flush) state_nx = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q   <= DIV;
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      negq_q <= 1'b0;
      negr_q <= 1'b0;
      cnt_q  <= '0;
    end else if (start) begin
      op_q  <= op;
      cnt_q <= '0;
      dvs_q <= b_mag;
      if (div0) begin
        quo_q  <= '1;
        rem_q  <= srca;
        negq_q <= 1'b0;
        negr_q <= 1'b0;
      end else if (ovf) begin
        quo_q  <= srca;
        rem_q  <= '0;
        negq_q <= 1'b0;
        negr_q <= 1'b0;
      end else begin
        quo_q  <= a_mag;
        rem_q  <= '0;
        negq_q <= a_neg ^ b_neg;
        negr_q <= a_neg;
      end
    end else if ((state == BUSY) && !flush) begin
      quo_q <= {quo_q[62:0], ~trial[65]};
      rem_q <= trial[65] ? shifted[63:0] : trial[63:0];
      cnt_q <= cnt_q + 7'd1;
    end
  end

  u64   q_fix;
  u64   r_fix;
  logic is_rem;

  assign q_fix  = negq_q ? (~quo_q + 64'd1) : quo_q;
  assign r_fix  = negr_q ? (~rem_q + 64'd1) : rem_q;
  assign is_rem = (op_q == REM) || (op_q == REMU);

  assign exe_is_waiting = !reset && !flush
                        && (((state == IDLE) && valid)
                            || (state == BUSY));
  assign done   = !reset && !flush && (state == DONE);
  assign result = done ? (is_rem ? r_fix : q_fix) : 64'd0;

endmodule
